// File: rtl/video_obj_ctrl.sv
//-----------------------------------------------------------------------------
// video_obj_ctrl
//
// Per-frame object-table controller for the video overlay datapath. Holds
// position and fall speed for NUM_OBJ objects and presents them to the pixel
// renderer as packed vectors. Once per frame, on the falling edge of vertical
// blank, a sequencer walks the table one object per enabled cycle and either
// commits a pending host write or advances that object's animation.
//
// Host writes land in a pending slot per object. They are only accepted while
// the sequencer is idle, so the table the renderer sees never tears mid-scan.
//
// Optional build macro:
//   VIDEO_OBJ_FREEZE_EN - adds freeze_i; while high during a scan, objects
//                         without a pending write keep their position.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (overrides cen_i)
//   cen_i        video clock enable; all state advances only when high
//   vh_blank_i   {Vblank, Hblank}; only Vblank is used
//   freeze_i     (VIDEO_OBJ_FREEZE_EN only) hold animation during scan
//   wr_valid_i   host write request
//   wr_ready_o   host write accepted when valid & ready & cen_i
//   wr_idx_i     object index (indices >= NUM_OBJ are accepted and dropped)
//   wr_x_i       new x (clamped to H_ACTIVE-1)
//   wr_y_i       new y (clamped to V_ACTIVE-1)
//   wr_spd_i     new fall speed in lines/frame; 0 = static
//   obj_x_o      packed x, object k at [12k+11:12k]
//   obj_y_o      packed y, object k at [11k+10:11k]
//   frame_cnt_o  frames seen (wraps)
//   busy_o       high while scanning
//   done_o       one-enabled-cycle pulse after the last object is processed
//-----------------------------------------------------------------------------
module video_obj_ctrl #(
    parameter int NUM_OBJ  = 12,
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int X_JUMP   = 137
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cen_i,
    input  logic [1:0]            vh_blank_i,
`ifdef VIDEO_OBJ_FREEZE_EN
    input  logic                  freeze_i,
`endif
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [4:0]            wr_idx_i,
    input  logic [11:0]           wr_x_i,
    input  logic [10:0]           wr_y_i,
    input  logic [3:0]            wr_spd_i,
    output logic [12*NUM_OBJ-1:0] obj_x_o,
    output logic [11*NUM_OBJ-1:0] obj_y_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // state   | meaning
    // --------+---------------------------------------------------------
    // ST_IDLE | waiting for end of vblank; host writes accepted
    // ST_SCAN | one object per enabled cycle; host writes stalled
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [4:0]  LAST_IDX = 5'(NUM_OBJ - 1);
    localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - 1);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - 1);
    localparam logic [11:0] X_LIMIT  = 12'(H_ACTIVE);
    localparam logic [10:0] Y_LIMIT  = 11'(V_ACTIVE);
    localparam logic [12:0] H_ACT_13 = 13'(H_ACTIVE);
    localparam logic [11:0] V_ACT_12 = 12'(V_ACTIVE);
    localparam logic [12:0] X_JMP_13 = 13'(X_JUMP);

    // object table and pending write slots
    logic [11:0]        r_x        [NUM_OBJ];
    logic [10:0]        r_y        [NUM_OBJ];
    logic [3:0]         r_spd      [NUM_OBJ];
    logic [11:0]        r_pend_x   [NUM_OBJ];
    logic [10:0]        r_pend_y   [NUM_OBJ];
    logic [3:0]         r_pend_spd [NUM_OBJ];
    logic [NUM_OBJ-1:0] r_pend_valid;

    // sequencer
    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_idx;
    logic [15:0] r_frame_cnt;
    logic        r_done;
    logic        r_vd;

    logic        w_vf;
    logic        w_scan_start;
    logic        w_scan_last;
    logic        w_wr_fire;
    logic        w_freeze;
    logic        w_unused_hblank;

    // clamped host data
    logic [11:0] w_wr_x;
    logic [10:0] w_wr_y;

    // object currently addressed by the scan and its animated next value
    logic [11:0] w_cur_x;
    logic [10:0] w_cur_y;
    logic [3:0]  w_cur_spd;
    logic [11:0] w_sum_y;
    logic [12:0] w_jump_x;
    logic [11:0] w_new_x;
    logic [10:0] w_new_y;

    assign w_unused_hblank = vh_blank_i[0];

`ifdef VIDEO_OBJ_FREEZE_EN
    assign w_freeze = freeze_i;
`else
    assign w_freeze = 1'b0;
`endif

    // Vblank falling edge: registered Vblank high, live Vblank low.
    assign w_vf = r_vd & ~vh_blank_i[1];

    //-------------------------------------------------------------------------
    // FSM
    //-------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else if (cen_i) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_scan_start = 1'b0;
        w_scan_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vf) begin
                    w_state_nxt  = ST_SCAN;
                    w_scan_start = 1'b1;
                end
            end
            ST_SCAN: begin
                // a VF seen here is deliberately ignored
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_scan_last = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign wr_ready_o = (r_state == ST_IDLE);
    assign busy_o     = (r_state == ST_SCAN);
    assign w_wr_fire  = wr_valid_i & wr_ready_o;

    //-------------------------------------------------------------------------
    // Host write clamping
    //-------------------------------------------------------------------------
    assign w_wr_x = (wr_x_i >= X_LIMIT) ? X_MAX : wr_x_i;
    assign w_wr_y = (wr_y_i >= Y_LIMIT) ? Y_MAX : wr_y_i;

    //-------------------------------------------------------------------------
    // Animation of the object under the scan pointer. A decoded select is
    // used instead of array indexing so the 5-bit pointer never addresses
    // past the table for NUM_OBJ < 32.
    //-------------------------------------------------------------------------
    always_comb begin
        w_cur_x   = '0;
        w_cur_y   = '0;
        w_cur_spd = '0;
        for (int k = 0; k < NUM_OBJ; k++) begin
            if (r_idx == 5'(k)) begin
                w_cur_x   = r_x[k];
                w_cur_y   = r_y[k];
                w_cur_spd = r_spd[k];
            end
        end
    end

    always_comb begin
        w_sum_y  = {1'b0, w_cur_y} + {8'b0, w_cur_spd};
        w_jump_x = {1'b0, w_cur_x} + X_JMP_13;
        w_new_x  = w_cur_x;
        w_new_y  = w_sum_y[10:0];
        if (w_sum_y >= V_ACT_12) begin
            // fell off the bottom: restart at the top, shifted right
            w_new_y = '0;
            if (w_jump_x >= H_ACT_13) begin
                w_jump_x = w_jump_x - H_ACT_13;
            end
            w_new_x = w_jump_x[11:0];
        end
    end

    //-------------------------------------------------------------------------
    // Datapath
    //-------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vd         <= 1'b0;
            r_idx        <= '0;
            r_frame_cnt  <= '0;
            r_done       <= 1'b0;
            r_pend_valid <= '0;
            for (int k = 0; k < NUM_OBJ; k++) begin
                r_x[k]        <= 12'((k * H_ACTIVE) / NUM_OBJ);
                r_y[k]        <= '0;
                r_spd[k]      <= 4'((k % 8) + 1);
                r_pend_x[k]   <= '0;
                r_pend_y[k]   <= '0;
                r_pend_spd[k] <= '0;
            end
        end else if (cen_i) begin
            r_vd   <= vh_blank_i[1];
            r_done <= w_scan_last;

            if (w_scan_start) begin
                r_idx       <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (r_state == ST_SCAN) begin
                r_idx <= r_idx + 5'd1;
            end

            for (int k = 0; k < NUM_OBJ; k++) begin
                // writes only fire in IDLE, commits only in SCAN, so the
                // two never touch the same pending slot in one cycle
                if (w_wr_fire && (wr_idx_i == 5'(k))) begin
                    r_pend_x[k]     <= w_wr_x;
                    r_pend_y[k]     <= w_wr_y;
                    r_pend_spd[k]   <= wr_spd_i;
                    r_pend_valid[k] <= 1'b1;
                end

                if ((r_state == ST_SCAN) && (r_idx == 5'(k))) begin
                    if (r_pend_valid[k]) begin
                        r_x[k]          <= r_pend_x[k];
                        r_y[k]          <= r_pend_y[k];
                        r_spd[k]        <= r_pend_spd[k];
                        r_pend_valid[k] <= 1'b0;
                    end else if (!w_freeze) begin
                        r_x[k] <= w_new_x;
                        r_y[k] <= w_new_y;
                    end
                end
            end
        end
    end

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_pack
        assign obj_x_o[12*g +: 12] = r_x[g];
        assign obj_y_o[11*g +: 11] = r_y[g];
    end

    assign frame_cnt_o = r_frame_cnt;
    assign done_o      = r_done;

endmodule

// File: doc/video_obj_ctrl.md
Name: video_obj_ctrl

Overview:
- Per-frame object-table controller for the video overlay datapath. Holds position and speed for NUM_OBJ falling objects and exposes them to the pixel renderer as packed vectors.
- Once per frame, on leaving vertical blank, a sequencer walks the table one object per enabled cycle. For each object it either commits a pending host write or advances the animation.
- The host side writes objects through a valid/ready port. Writes are only accepted outside the scan, so the table the renderer sees never tears.

Parameters:
- NUM_OBJ, 12, number of objects (2..32)
- H_ACTIVE, 1920, active pixels per line; x range 0..H_ACTIVE-1
- V_ACTIVE, 1080, active lines; y range 0..V_ACTIVE-1
- X_JUMP, 137, x increment applied when an object wraps from bottom to top

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cen_i  in  1  video clock enable; all state advances only when high
- vh_blank_i  in  2  {Vblank, Hblank}; only bit 1 is used
- wr_valid_i  in  1  host write request
- wr_ready_o  out  1  host write accepted when valid & ready & cen_i
- wr_idx_i  in  5  object index
- wr_x_i  in  12  new x
- wr_y_i  in  11  new y
- wr_spd_i  in  4  new fall speed in lines/frame; 0 = static
- obj_x_o  out  12*NUM_OBJ  packed x; object k at [12k+11:12k]
- obj_y_o  out  11*NUM_OBJ  packed y; object k at [11k+10:11k]
- frame_cnt_o  out  16  frames seen
- busy_o  out  1  high during SCAN
- done_o  out  1  one-cen-cycle pulse at end of scan

Behaviour:
- Clock enable: when cen_i is low, all registers hold and there are no pulses. "Cycle" below means a cen_i-qualified cycle.
- Reset (clk_i edge with rst_i=1, overrides cen_i):
  - x[k] = (k*H_ACTIVE/NUM_OBJ), using integer division.
  - y[k] = 0; spd[k] = (k%8)+1; all pend_valid cleared.
  - State IDLE; frame_cnt_o = 0; busy_o = 0; done_o = 0; wr_ready_o = 1.
  - A reset during SCAN abandons the scan; no partial commit survives.
- VF detection: vd is bit 1 of vh_blank_i registered on cen. VF = vd & ~vh_blank_i[1].
- FSM has two states, IDLE and SCAN.
  - IDLE: on VF, go to SCAN, set idx=0, and increment frame_cnt_o (16-bit, wraps 0xFFFF->0).
  - SCAN: process object idx each cycle. When idx==NUM_OBJ-1, go to IDLE and assert done_o for the next cycle only.
  - A VF that arrives during SCAN is ignored; frame_cnt_o does not increment.
- Latency: if VF is seen in cycle t, object k is updated at the end of cycle t+1+k. done_o is high in cycle t+1+NUM_OBJ.
- Per-object processing in SCAN, for object k:
  - If pend_valid[k] is set: load x, y, spd from the pending slot and clear pend_valid[k]. No animation is applied this frame.
  - Else compute s = y+spd at 12-bit width.
    - If s >= V_ACTIVE: y = 0 and x = x+X_JUMP, subtracting H_ACTIVE once if the result is >= H_ACTIVE.
    - Otherwise y = s.
- Host writes:
  - wr_ready_o = (state==IDLE). It is combinational from registered state.
  - An accepted write stores into pending slot wr_idx_i and sets pend_valid.
  - A second write to the same index before the scan overwrites the slot; last write wins.
  - Writes with wr_idx_i >= NUM_OBJ are accepted and discarded.
  - Clamping: wr_x_i >= H_ACTIVE is stored as H_ACTIVE-1; wr_y_i >= V_ACTIVE is stored as V_ACTIVE-1.
  - A write and VF in the same IDLE cycle: the write is accepted first and is committed by the scan that starts next cycle.
- obj_x_o and obj_y_o are registered and change only during SCAN or reset.
- busy_o = (state==SCAN).

Optional Feature:
- Macro VIDEO_OBJ_FREEZE_EN.
- When defined: adds input freeze_i (1 bit). While freeze_i is high during SCAN, non-pending objects keep x and y unchanged. Pending writes still commit, and frame_cnt_o still counts.
- When undefined: no freeze_i port; animation always runs.

Test Plan:
- Reset, then first VF with cen_i=1 every cycle -> obj 0 (spd 1) reads y=1, x=0; obj 1 reads y=2, x=160. done_o pulses 13 cycles after VF; frame_cnt_o=1.
- wr idx=3, x=500, y=1075, spd=9 in IDLE, then VF -> obj 3 = (500,1075). Next VF: s=1084 >= 1080, so y=0 and x=637.
- Wrap plus x modulo: preload obj 5 with x=1900, y=1079, spd=1, then VF -> y=0, x=117.
- Hold wr_valid_i through a VF -> wr_ready_o low for 12 cycles. A write held across SCAN is accepted on the first IDLE cycle and committed next frame.
- cen_i toggled 1/0 during SCAN -> outputs match the cen_i=1 run cycle-for-cycle on enabled edges. Assert rst_i mid-SCAN -> all reset values next edge, busy_o=0.
- Write wr_x_i=4000 and wr_idx_i=20 -> x is stored as 1919 for the valid index; the index-20 write leaves all objects unchanged.
